// File: rtl/hornet_mem_arb_pkg.sv
// rtl/hornet_mem_arb_pkg.sv - shared types and sizes for the hornet memory arbiter
package hornet_pkg;

   localparam int HORNET_DW = 18;
   localparam int HORNET_AW = 6;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_ACC  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/hornet_mem_arb_if.sv
// rtl/hornet_mem_arb_if.sv - core/host request buses and status of the hornet memory arbiter
interface hornet_mem_arb_if #(
   parameter int DW = 18,
   parameter int AW = 6
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_adr;
   logic [DW-1:0] c_wdat;
   logic          c_ack;
   logic          h_req;
   logic          h_we;
   logic [AW-1:0] h_adr;
   logic [DW-1:0] h_wdat;
   logic          h_ack;
   logic          h_halt;
   logic [DW-1:0] rdat;
   logic [1:0]    owner;
   logic          busy;

   modport master (
      output c_req, c_we, c_adr, c_wdat, h_req, h_we, h_adr, h_wdat, h_halt,
      input  c_ack, h_ack, rdat, owner, busy
   );

   modport slave (
      input  c_req, c_we, c_adr, c_wdat, h_req, h_we, h_adr, h_wdat, h_halt,
      output c_ack, h_ack, rdat, owner, busy
   );
endinterface

// File: rtl/hornet_mem_arb_spram.sv
// rtl/hornet_mem_arb_spram.sv - single-port array, write-first, one-cycle registered read
module hornet_spram #(
   parameter int DW = 18,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] adr,
   input  logic [DW-1:0] wdat,
   output logic [DW-1:0] q
);
   logic [DW-1:0] mem [0:(2**AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[adr] <= wdat;
         q        <= wdat;
      end else begin
         q <= mem[adr];
      end
   end
endmodule

// File: rtl/hornet_mem_arb.sv
// rtl/hornet_mem_arb.sv - core-priority arbiter for the hornet program/data memory
// Host gets a bounded wait; every access is issue (IDLE) then ack (ACC).
module hornet_mem_arb
   import hornet_pkg::*;
#(
   parameter int DW       = HORNET_DW,
   parameter int AW       = HORNET_AW,
   parameter int WAIT_MAX = 3
) (
   input  logic            clk,
   input  logic            reset,
   hornet_mem_arb_if.slave bus
);
   localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

   arb_state_t    state, state_nxt;
   owner_t        owner_q, owner_nxt;
   logic [3:0]    wcnt, wcnt_nxt;
   logic          core_elig, host_elig;
   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdat;
   logic [DW-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ARB_IDLE;
         owner_q <= OWN_NONE;
         wcnt    <= '0;
      end else begin
         state   <= state_nxt;
         owner_q <= owner_nxt;
         wcnt    <= wcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner_q;
      wcnt_nxt  = wcnt;
      mem_we    = 1'b0;
      mem_adr   = bus.c_adr;
      mem_wdat  = bus.c_wdat;
      core_elig = bus.c_req & ~bus.h_halt;
      host_elig = bus.h_req;
      unique case (state)
         ARB_IDLE: begin
            // host wins only when the core is absent or has used up its allowance
            if (host_elig && (!core_elig || wcnt == WAIT_LIM)) begin
               state_nxt = ARB_ACC;
               owner_nxt = OWN_HOST;
               mem_adr   = bus.h_adr;
               mem_wdat  = bus.h_wdat;
               mem_we    = bus.h_we;
               wcnt_nxt  = '0;
            end else if (core_elig) begin
               state_nxt = ARB_ACC;
               owner_nxt = OWN_CORE;
               mem_we    = bus.c_we;
               if (!bus.h_req)
                  wcnt_nxt = '0;
               else if (wcnt != WAIT_LIM)
                  wcnt_nxt = wcnt + 4'd1;
            end else begin
               wcnt_nxt = '0;
            end
         end
         ARB_ACC: begin
            state_nxt = ARB_IDLE;
            owner_nxt = OWN_NONE;
            if (!bus.h_req)
               wcnt_nxt = '0;
         end
         default: begin
            state_nxt = ARB_IDLE;
            owner_nxt = OWN_NONE;
         end
      endcase
   end

   // a write issued on a reset edge must not reach the array
   hornet_spram #(
      .DW (DW),
      .AW (AW)
   ) u_spram (
      .clk  (clk),
      .we   (mem_we & ~reset),
      .adr  (mem_adr),
      .wdat (mem_wdat),
      .q    (mem_q)
   );

   assign bus.busy  = (state == ARB_ACC);
   assign bus.c_ack = bus.busy && (owner_q == OWN_CORE);
   assign bus.h_ack = bus.busy && (owner_q == OWN_HOST);
   assign bus.rdat  = bus.busy ? mem_q : '0;
   assign bus.owner = owner_q;
endmodule

// File: tb/tb_hornet_mem_arb.sv
// tb/tb_hornet_mem_arb.sv - directed self-checking bench for hornet_mem_arb
module tb_hornet_mem_arb;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   hornet_mem_arb_if #(.DW(18), .AW(6)) bus ();

   hornet_mem_arb #(.DW(18), .AW(6), .WAIT_MAX(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   logic [1:0] exp_seq [16] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0,
                                2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one isolated access: issue edge, ack cycle, then return to idle
   task automatic do_acc(input bit host, input bit we, input logic [5:0] adr,
                         input logic [17:0] wdat, input logic [17:0] exp, input string tag);
      if (host) begin
         bus.h_req = 1'b1; bus.h_we = we; bus.h_adr = adr; bus.h_wdat = wdat;
      end else begin
         bus.c_req = 1'b1; bus.c_we = we; bus.c_adr = adr; bus.c_wdat = wdat;
      end
      tick();
      chk({tag, "_ack"}, {30'd0, bus.h_ack, bus.c_ack}, host ? 32'd2 : 32'd1);
      chk({tag, "_owner"}, {30'd0, bus.owner}, host ? 32'd2 : 32'd1);
      chk({tag, "_rdat"}, {14'd0, bus.rdat}, {14'd0, exp});
      if (host) bus.h_req = 1'b0;
      else      bus.c_req = 1'b0;
      tick();
      chk({tag, "_idle"}, {12'd0, bus.h_ack, bus.c_ack, bus.owner, bus.busy, bus.rdat},
          32'd0);
   endtask

   initial begin
      reset = 1'b1;
      bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_adr = '0; bus.c_wdat = '0;
      bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_adr = '0; bus.h_wdat = '0;
      bus.h_halt = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_c_ack", {31'd0, bus.c_ack}, 32'd0);
      chk("rst_h_ack", {31'd0, bus.h_ack}, 32'd0);
      chk("rst_rdat", {14'd0, bus.rdat}, 32'd0);
      chk("rst_owner", {30'd0, bus.owner}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);

      // test 1: host write then core read of adr 5
      do_acc(1'b1, 1'b1, 6'd5, 18'h2C9B2, 18'h2C9B2, "t1_hwr");
      do_acc(1'b0, 1'b0, 6'd5, 18'h00000, 18'h2C9B2, "t1_crd");

      // preload for later tests
      do_acc(1'b1, 1'b1, 6'd0,  18'h1A5A5, 18'h1A5A5, "pre0");
      do_acc(1'b1, 1'b1, 6'd1,  18'h2F00F, 18'h2F00F, "pre1");
      do_acc(1'b1, 1'b1, 6'd2,  18'h03C3C, 18'h03C3C, "pre2");
      do_acc(1'b1, 1'b1, 6'd3,  18'h35555, 18'h35555, "pre3");
      do_acc(1'b1, 1'b1, 6'd9,  18'h12345, 18'h12345, "pre9");
      do_acc(1'b1, 1'b1, 6'd63, 18'h3ABCD, 18'h3ABCD, "pre63");

      // test 2: both requesting continuously, expect C C C H C C C H
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_adr = 6'd0;
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_adr = 6'd1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("t2_ack%0d", i), {30'd0, bus.h_ack, bus.c_ack}, {30'd0, exp_seq[i]});
      end
      bus.c_req = 1'b0;
      bus.h_req = 1'b0;
      tick();
      chk("t2_idle", {30'd0, bus.h_ack, bus.c_ack}, 32'd0);

      // test 3: halted core, host reads preloaded words
      bus.h_halt = 1'b1;
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_adr = 6'd0;
      tick();
      chk("t3_halt_noack", {30'd0, bus.h_ack, bus.c_ack}, 32'd0);
      do_acc(1'b1, 1'b0, 6'd0, 18'h0, 18'h1A5A5, "t3_h0");
      do_acc(1'b1, 1'b0, 6'd1, 18'h0, 18'h2F00F, "t3_h1");
      do_acc(1'b1, 1'b0, 6'd2, 18'h0, 18'h03C3C, "t3_h2");
      do_acc(1'b1, 1'b0, 6'd3, 18'h0, 18'h35555, "t3_h3");
      bus.h_halt = 1'b0;
      tick();
      chk("t3_release_ack", {30'd0, bus.h_ack, bus.c_ack}, 32'd1);
      chk("t3_release_rdat", {14'd0, bus.rdat}, 32'h1A5A5);
      bus.c_req = 1'b0;
      tick();

      // test 4: back-to-back core reads wrapping 63 -> 0 with req held
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_adr = 6'd63;
      tick();
      chk("t4_ack63", {31'd0, bus.c_ack}, 32'd1);
      chk("t4_rdat63", {14'd0, bus.rdat}, 32'h3ABCD);
      bus.c_adr = 6'd0;
      tick();
      chk("t4_gap_ack", {31'd0, bus.c_ack}, 32'd0);
      chk("t4_gap_rdat", {14'd0, bus.rdat}, 32'd0);
      tick();
      chk("t4_ack0", {31'd0, bus.c_ack}, 32'd1);
      chk("t4_rdat0", {14'd0, bus.rdat}, 32'h1A5A5);
      bus.c_req = 1'b0;
      tick();
      chk("t4_end_rdat", {14'd0, bus.rdat}, 32'd0);

      // test 5: reset on the issue edge of a host write
      bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_adr = 6'd9; bus.h_wdat = 18'h3FFFF;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.h_req = 1'b0;
      chk("t5_outs", {12'd0, bus.h_ack, bus.c_ack, bus.owner, bus.busy, bus.rdat}, 32'd0);
      tick();
      chk("t5_noack", {30'd0, bus.h_ack, bus.c_ack}, 32'd0);
      do_acc(1'b1, 1'b0, 6'd9, 18'h0, 18'h12345, "t5_rd9");

      // test 6: core write-first then host readback
      do_acc(1'b0, 1'b1, 6'd2, 18'h00001, 18'h00001, "t6_cwr");
      do_acc(1'b1, 1'b0, 6'd2, 18'h0, 18'h00001, "t6_hrd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/hornet_mem_arb.md
Name: hornet_mem_arb

Overview:
Two-requester arbiter and sequencer for the hornet core's single-port 64 x 18 program/data memory. It shares the memory between the core fetch/data port and a host loader/debug port. Each requester uses a req/ack handshake. The core has priority, with a bounded-wait guarantee for the host and a host-controlled halt of core access. The block sits between the hornet core and the memory array and owns the array as a sub-module.

Parameters:
DW, 18, data word width
AW, 6, address width; memory depth is 2**AW
WAIT_MAX, 3, consecutive core grants allowed while the host is pending before the host is forced through (1..15)

Ports:
clk  input  1  clock; all state on the rising edge
reset  input  1  synchronous, active-high reset
c_req  input  1  core access request; held until c_ack
c_we  input  1  core write enable; stable while c_req is high
c_adr  input  AW  core address
c_wdat  input  DW  core write data
c_ack  output  1  one-cycle pulse: core access complete
h_req  input  1  host access request; held until h_ack
h_we  input  1  host write enable
h_adr  input  AW  host address
h_wdat  input  DW  host write data
h_ack  output  1  one-cycle pulse: host access complete
h_halt  input  1  while high, the core is never granted
rdat  output  DW  read data; valid only in the ack cycle, 0 otherwise
owner  output  2  0 = none, 1 = core, 2 = host; owner of the access in flight
busy  output  1  high in the ACC state

Behaviour:
- Reset (reset high at a clock edge):
  - state goes to IDLE; c_ack, h_ack, rdat, owner, busy and the wait counter all go to 0.
  - Memory contents are not reset.
  - An issue coinciding with reset commits no write.
- States: IDLE and ACC.
- IDLE, arbitration:
  - Eligible core = c_req & ~h_halt; eligible host = h_req.
  - Both eligible: grant the host if wcnt == WAIT_MAX, otherwise grant the core.
  - Only one eligible: grant it. Neither: stay in IDLE with no memory access.
- Issue (IDLE with a grant):
  - Drive the granted requester's address to the array.
  - If we=1, write wdat at that edge.
  - owner <= granted id; next state is ACC.
- ACC, exactly one cycle:
  - Pulse the granted requester's ack.
  - rdat = array output (registered read of the issued address).
  - For a write, rdat = the written data (write-first).
  - Next state is IDLE; owner <= 0.
- Latency and throughput:
  - Latency from issue edge to ack is 1 cycle; from req seen in IDLE to ack is 2 edges.
  - Throughput is one access per 2 cycles. This is required: a requester may keep req high after ack for its next access, and the mandatory return to IDLE makes that safe.
- Requests arriving during ACC are evaluated in the next IDLE cycle.
- Wait counter wcnt (4 bits):
  - Core granted while h_req=1: wcnt <= wcnt+1, saturating at WAIT_MAX.
  - Host granted, or h_req=0: wcnt <= 0.
- Host worst-case wait is therefore WAIT_MAX core accesses.
- h_halt takes effect at the next IDLE arbitration. An access already in ACC completes normally.
- Requests are only examined in IDLE. Dropping req before ack is illegal; the block behaviour in that case is don't-care, but it must not deadlock (ACC always returns to IDLE).
- Addresses wrap naturally modulo 2**AW; there is no out-of-range condition.
- c_ack and h_ack are never high in the same cycle.

Decomposition:
- Shared package hornet_pkg holds:
  - owner_t enum (OWN_NONE = 0, OWN_CORE = 1, OWN_HOST = 2);
  - arb_state_t enum (ARB_IDLE, ARB_ACC);
  - HORNET_DW = 18 and HORNET_AW = 6.
- One sub-module, hornet_spram:
  - parameters DW and AW;
  - ports clk, we, adr, wdat, q;
  - synchronous write-first, 1-cycle read, no reset.
- Arbitration, the FSM, the wait counter and output gating live in hornet_mem_arb.

Test Plan:
1. Host write then core read: host writes adr 5 = 18'h2C9B2 (h_ack 1 cycle after issue), then core reads adr 5 → c_ack with rdat = 18'h2C9B2; owner sequences 2, 0, 1, 0.
2. Both requesting, WAIT_MAX = 3: c_req and h_req held continuously → grant order C, C, C, H, C, C, C, H; acks spaced 2 cycles apart; never both acks in the same cycle.
3. h_halt = 1 with c_req held and host reading adr 0..3 → no c_ack for the whole window; host reads return the preloaded values; after h_halt drops, c_ack within 2 cycles.
4. Back-to-back core reads at adr 63 then adr 0 (wrap), req held high across ack → exactly one ack per 2 cycles with the correct data; rdat = 0 in the non-ack cycles.
5. Reset asserted on the issue cycle of a host write of 18'h3FFFF to adr 9 → no h_ack; adr 9 keeps its old value; all outputs are 0 the cycle after reset.
6. Core write of 18'h00001 to adr 2, readback in the same ack cycle → rdat = 18'h00001 (write-first); a later host read of adr 2 returns 18'h00001.
